// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator behind a 2-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int SHIFT_BJ = 1,
    parameter int TAG_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] ill_count
);
    localparam bit RV64 = (XLEN == 64);
    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6, F_INV = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t           state_q, state_d;
    entry_t           pri_q, pri_d, skd_q, skd_d, dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, drain, is_sh;
    logic [6:0]       op;
    logic [2:0]       f3, fmt;
    logic [5:0]       shamt;
    logic signed [31:0] i_imm, s_imm, b_imm, j_imm, u_imm, imm32;

    always_comb begin
        op    = in_inst[6:0];
        f3    = in_inst[14:12];
        is_sh = (f3 == 3'b001) || (f3 == 3'b101);
        i_imm = 32'($signed(in_inst[31:20]));
        s_imm = 32'($signed({in_inst[31:25], in_inst[11:7]}));
        b_imm = 32'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
        j_imm = 32'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
        b_imm = (SHIFT_BJ != 0) ? b_imm : b_imm >>> 1;
        j_imm = (SHIFT_BJ != 0) ? j_imm : j_imm >>> 1;
        u_imm = {in_inst[31:12], 12'b0};
        shamt = {RV64 && (op == 7'b0010011) && in_inst[25], in_inst[24:20]};
        fmt   = F_INV;
        imm32 = '0;
        case (op)
            7'b0110111, 7'b0010111: begin fmt = F_U; imm32 = u_imm; end
            7'b1101111: begin fmt = F_J; imm32 = j_imm; end
            7'b1100111, 7'b0000011, 7'b0001111, 7'b1110011: begin fmt = F_I; imm32 = i_imm; end
            7'b0100011: begin fmt = F_S; imm32 = s_imm; end
            7'b1100011: begin fmt = F_B; imm32 = b_imm; end
            7'b0010011: begin
                fmt   = is_sh ? F_SH : F_I;
                imm32 = is_sh ? 32'(shamt) : i_imm;
            end
            7'b0110011: fmt = F_NONE;
            7'b0011011: begin
                fmt   = !RV64 ? F_INV : is_sh ? F_SH : F_I;
                imm32 = !RV64 ? '0 : is_sh ? 32'(shamt) : i_imm;
            end
            7'b0111011: fmt = RV64 ? F_NONE : F_INV;
            default: fmt = F_INV;
        endcase
        dec.imm = XLEN'(imm32);
        dec.fmt = fmt;
        dec.ill = (fmt == F_INV);
        dec.tag = in_tag;
    end

    assign in_ready    = rst_n && (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign accept      = in_valid && in_ready;
    assign drain       = out_valid && out_ready;
    assign out_imm     = pri_q.imm;
    assign out_fmt     = pri_q.fmt;
    assign out_illegal = pri_q.ill;
    assign out_tag     = pri_q.tag;
    assign ill_count   = cnt_q;

    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        skd_d   = skd_q;
        cnt_d   = (accept && !flush && dec.ill && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    pri_d   = dec;
                    state_d = BUSY;
                end
                BUSY: begin
                    pri_d   = (accept && drain) ? dec : pri_q;
                    skd_d   = (accept && !drain) ? dec : skd_q;
                    state_d = (accept && !drain) ? FULL : (!accept && drain) ? EMPTY : BUSY;
                end
                FULL: if (drain) begin
                    pri_d   = skd_q;
                    state_d = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            pri_q   <= '0;
            skd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            skd_q   <= skd_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator for the decode stage of the next processor revision.
- Decodes the immediate for every RV32I/RV64I base format, sign-extends it to XLEN and tags it with a format code and an illegal flag.
- Passes the result downstream through a 2-entry skid buffer with valid/ready handshakes on both sides, plus a flush and an illegal-instruction counter.
- Replaces the combinational generator in the pipelined core.

Parameters:
XLEN, 32, output width; legal values 32 or 64; 64 enables the OP-IMM-32/OP-32 opcodes and 6-bit shamt
SHIFT_BJ, 1, 1 = B/J immediates include bit0=0 (byte offset); 0 = emit halfword offset (imm>>1) for cores with an external shift-left
TAG_W, 32, width of the sideband tag (PC) carried alongside the instruction
CNT_W, 16, width of the illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous pipeline flush, discards all buffered entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept an instruction this cycle
in_inst  in  32  instruction word
in_tag  in  TAG_W  sideband tag, passed through unchanged
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts the output entry
out_imm  out  XLEN  generated immediate
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 INVALID
out_illegal  out  1  opcode unsupported or inst[1:0]!=2'b11
out_tag  out  TAG_W  tag of the output entry
ill_count  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Decode is combinational on in_inst and is captured on accept.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Format by opcode:
  - 0110111/0010111 -> U: {inst[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
  - 1101111 -> J.
  - 1100111, 0000011, 0001111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0010011 -> I, except funct3 001/101 -> SHAMT.
  - 0110011 -> NONE, imm 0.
  - XLEN=64 only: 0011011 -> I or SHAMT (funct3 001/101); 0111011 -> NONE.
  - Anything else -> INVALID, imm 0, out_illegal=1.
- Extension rules:
  - I/S/B/J are always sign-extended from the top immediate bit, regardless of funct3. This includes SLTIU, LBU/LHU and BLTU/BGEU.
  - SHAMT is zero-extended: inst[24:20] for XLEN=32 and for 0011011; inst[25:20] for 0010011 when XLEN=64.
  - B/J: SHIFT_BJ=1 emits full offset with bit0=0; SHIFT_BJ=0 emits offset>>1, still sign-extended.
- Buffer FSM states:
  - EMPTY: accept -> BUSY, primary loaded.
  - BUSY: accept&drain -> BUSY, primary reloaded; accept&!drain -> FULL, skid loaded; !accept&drain -> EMPTY.
  - FULL: drain -> BUSY, primary<=skid; no accept possible.
- Handshake rules:
  - in_ready = rst_n & (state!=FULL), derived from registered state only; no combinational path from out_ready.
  - out_valid = (state!=EMPTY).
  - Outputs hold stable while out_valid & !out_ready.
  - Latency: 1 cycle from accept to out_valid when EMPTY or when draining.
  - Ordering is strictly FIFO; no entry is lost or duplicated.
- Flush:
  - Highest priority after reset; state -> EMPTY next cycle.
  - An input presented in the flush cycle is discarded and not counted.
  - ill_count is unaffected.
- ill_count:
  - Increments by 1 per accepted illegal instruction.
  - Saturates at all-ones.
  - Cleared only by reset.
- Reset (rst_n=0 at posedge):
  - State EMPTY; out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, ill_count=0.
  - in_ready=0 while rst_n is low.
  - Reset mid-operation discards all entries.

Test Plan:
- XLEN=32, 0x123450B7 (LUI), out_ready=1 -> one cycle later out_valid=1, out_imm=0x12345000, out_fmt=4.
- 0xFE20EEE3 (BLTU x1,x2,-4) -> SHIFT_BJ=1: out_imm=0xFFFFFFFC, fmt 3; SHIFT_BJ=0: out_imm=0xFFFFFFFE.
- XLEN=64, 0x4030D093 (SRAI x1,x1,3) -> out_imm=0x0000000000000003, fmt 6; LUI 0x800000B7 -> out_imm=0xFFFFFFFF80000000.
- out_ready=0, three back-to-back valid inputs with tags 1,2,3 -> in_ready drops after tag 2 accepted; tag 1 held stable; release out_ready -> tags 1,2,3 emerge in order, one per cycle, then out_valid=0.
- CNT_W=2, five accepted 0xFFFFFFFF -> each out_fmt=7, out_illegal=1, out_imm=0; ill_count sequence 1,2,3,3,3.
- State FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, ill_count unchanged; repeat with rst_n=0 instead -> in_ready=0 during reset, ill_count=0 after.
